umtrx_tx_err_arb: RTL and testbench

Packet-level round-robin arbiter that merges the 36-bit error/status streams of all UmTRX TX chains into the single sys-clock-domain error path toward the protocol framer. It sits on sys_clk after each chain's dsp-to-sys clock-crossing FIFO. It forwards whole packets without interleaving. A settings-bus enable mask lets software drain and drop a channel's reports.

---
 rtl/umtrx_tx_err_arb_pkg.sv | 20 ++
 rtl/umtrx_rr_pick.sv | 33 +++
 rtl/umtrx_tx_err_arb.sv | 146 ++++++++++++++
 tb/tb_umtrx_tx_err_arb.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/umtrx_tx_err_arb_pkg.sv
// Shared constants and state encoding for the UmTRX TX error-stream arbiter.
// Word layout: [31:0] payload, [32] SOF, [33] EOF, [35:34] passed through untouched.
package umtrx_tx_err_arb_pkg;

    localparam int SOF_BIT      = 32;
    localparam int EOF_BIT      = 33;

    localparam int REG_EN_MASK  = 0;
    localparam int REG_DROP_CLR = 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic is_eof(input logic [35:0] word);
        return word[EOF_BIT];
    endfunction

endpackage

// File: rtl/umtrx_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping over NUM_CHAN.
module umtrx_rr_pick #(
    parameter int NUM_CHAN = 2
) (
    input  logic [NUM_CHAN-1:0] req,
    input  logic [1:0]          last,
    output logic                found,
    output logic [1:0]          sel
);

    logic [3:0] req_pad;

    assign req_pad = 4'(req);

    always_comb begin
        int         cand;
        logic [1:0] idx;
        found = 1'b0;
        sel   = 2'd0;
        cand  = 0;
        idx   = 2'd0;
        // The channel just served is visited last, giving it lowest priority.
        for (int i = 1; i <= NUM_CHAN; i++) begin
            cand = (int'(last) + i) % NUM_CHAN;
            idx  = cand[1:0];
            if (!found && req_pad[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

endmodule

// File: rtl/umtrx_tx_err_arb.sv
// Packet-level round-robin merge of per-chain TX error streams onto one sys_clk path.
// Whole packets are forwarded without interleaving; disabled channels are drained and counted.
//
//   state | meaning
//   IDLE  | no packet in flight; pick next enabled requester after 'last'
//   BUSY  | muxing granted channel straight through until its EOF word transfers
module umtrx_tx_err_arb
    import umtrx_tx_err_arb_pkg::*;
#(
    parameter int NUM_CHAN = 2,
    parameter int BASE     = 0
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     set_stb,
    input  logic [7:0]               set_addr,
    input  logic [31:0]              set_data,
    input  logic [36*NUM_CHAN-1:0]   in_data,
    input  logic [NUM_CHAN-1:0]      in_valid,
    output logic [NUM_CHAN-1:0]      in_ready,
    output logic [35:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              drop_count
);

    localparam logic [7:0] ADDR_EN_MASK  = 8'(BASE + REG_EN_MASK);
    localparam logic [7:0] ADDR_DROP_CLR = 8'(BASE + REG_DROP_CLR);

    arb_state_t          state, state_nxt;
    logic [1:0]          grant, grant_nxt;
    logic [1:0]          last, last_nxt;
    logic [NUM_CHAN-1:0] en_mask;
    logic [15:0]         drop_cnt;

    logic [35:0]         in_word [4];
    logic [3:0]          valid_pad;
    logic                pick_found;
    logic [1:0]          pick_sel;
    logic [NUM_CHAN-1:0] granted;
    logic [NUM_CHAN-1:0] drain;
    logic [2:0]          drain_cnt;
    logic [16:0]         drop_sum;
    logic                wr_en_mask;
    logic                wr_drop_clr;

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        if (g < NUM_CHAN) begin : g_used
            assign in_word[g] = in_data[36*g +: 36];
        end else begin : g_unused
            assign in_word[g] = '0;
        end
    end

    assign valid_pad = 4'(in_valid);

    umtrx_rr_pick #(
        .NUM_CHAN (NUM_CHAN)
    ) u_pick (
        .req   (in_valid & en_mask),
        .last  (last),
        .found (pick_found),
        .sel   (pick_sel)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            grant <= 2'd0;
            last  <= 2'(NUM_CHAN - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        out_valid = 1'b0;
        out_data  = in_word[grant];
        in_ready  = ~en_mask;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_sel;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                out_valid = valid_pad[grant];
                // The granted channel follows downstream even if it was disabled mid-packet.
                for (int k = 0; k < NUM_CHAN; k++) begin
                    if (grant == 2'(k)) begin
                        in_ready[k] = out_ready;
                    end
                end
                if (out_valid && out_ready && is_eof(out_data)) begin
                    last_nxt  = grant;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        granted   = '0;
        drain     = '0;
        drain_cnt = 3'd0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            granted[k] = (state == BUSY) && (grant == 2'(k));
            drain[k]   = !en_mask[k] && !granted[k] && in_valid[k] && is_eof(in_word[k]);
            if (drain[k]) begin
                drain_cnt = drain_cnt + 3'd1;
            end
        end
    end

    assign drop_sum    = {1'b0, drop_cnt} + 17'(drain_cnt);
    assign wr_en_mask  = set_stb && (set_addr == ADDR_EN_MASK);
    assign wr_drop_clr = set_stb && (set_addr == ADDR_DROP_CLR);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            en_mask  <= '1;
            drop_cnt <= 16'd0;
        end else begin
            if (wr_en_mask) begin
                en_mask <= set_data[NUM_CHAN-1:0];
            end
            if (wr_drop_clr) begin
                drop_cnt <= 16'd0;
            end else if (drop_sum[16]) begin
                drop_cnt <= 16'hFFFF;
            end else begin
                drop_cnt <= drop_sum[15:0];
            end
        end
    end

    assign drop_count = drop_cnt;

endmodule

// File: tb/tb_umtrx_tx_err_arb.sv
// Directed bench for umtrx_tx_err_arb with two channels: vector table plus handshake-driven sequences.
module tb_umtrx_tx_err_arb;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [71:0] in_data;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [35:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] drop_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [35:0] q0[$];
    logic [35:0] q1[$];

    typedef struct {
        logic [35:0] d0;
        logic        v0;
        logic        ordy;
        logic        ev;
        logic [35:0] ed;
        logic [1:0]  erdy;
    } vec_t;

    typedef struct {
        logic        ev;
        logic [35:0] ed;
        logic [1:0]  erdy;
    } exp_t;

    umtrx_tx_err_arb #(
        .NUM_CHAN (2),
        .BASE     (0)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_count (drop_count)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%09h expected 0x%09h", nm, act, exp);
        end
    endtask

    // One clock: present queue heads, check outputs mid-cycle, pop words that handshook.
    task automatic cyc(input logic ordy, input logic ev, input logic [35:0] ed,
                       input logic [1:0] erdy, input string nm);
        logic p0, p1;
        @(negedge sys_clk);
        out_ready = ordy;
        in_valid  = {q1.size() > 0, q0.size() > 0};
        in_data   = {(q1.size() > 0) ? q1[0] : 36'h0, (q0.size() > 0) ? q0[0] : 36'h0};
        #1;
        check({nm, ".out_valid"}, 36'(out_valid), 36'(ev));
        if (ev) check({nm, ".out_data"}, out_data, ed);
        check({nm, ".in_ready"}, 36'(in_ready), 36'(erdy));
        p0 = in_valid[0] & in_ready[0];
        p1 = in_valid[1] & in_ready[1];
        @(posedge sys_clk);
        #1;
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
    endtask

    task automatic run_exp(input exp_t e[], input string nm);
        foreach (e[i]) cyc(1'b1, e[i].ev, e[i].ed, e[i].erdy, $sformatf("%s[%0d]", nm, i));
    endtask

    initial begin
        vec_t t1[5];
        exp_t e2[];

        sys_rst   = 1'b1;
        set_stb   = 1'b0;
        set_addr  = 8'h00;
        set_data  = 32'h0;
        in_data   = '0;
        in_valid  = 2'b00;
        out_ready = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        check("reset.drop_count", 36'(drop_count), 36'h0);

        // Both channels offer two 2-word packets back to back: ch0, ch1, ch0, ch1 with bubbles.
        q0 = '{36'h1_0000_0C01, 36'h2_0000_0C02, 36'h1_0000_0C03, 36'h2_0000_0C04};
        q1 = '{36'h1_0000_0D01, 36'h2_0000_0D02, 36'h1_0000_0D03, 36'h2_0000_0D04};
        e2 = '{
            '{1'b0, 36'h0,            2'b00},
            '{1'b1, 36'h1_0000_0C01,  2'b01},
            '{1'b1, 36'h2_0000_0C02,  2'b01},
            '{1'b0, 36'h0,            2'b00},
            '{1'b1, 36'h1_0000_0D01,  2'b10},
            '{1'b1, 36'h2_0000_0D02,  2'b10},
            '{1'b0, 36'h0,            2'b00},
            '{1'b1, 36'h1_0000_0C03,  2'b01},
            '{1'b1, 36'h2_0000_0C04,  2'b01},
            '{1'b0, 36'h0,            2'b00},
            '{1'b1, 36'h1_0000_0D03,  2'b10},
            '{1'b1, 36'h2_0000_0D04,  2'b10},
            '{1'b0, 36'h0,            2'b00}
        };
        run_exp(e2, "rr");

        // Channel 0 three-word packet, vector table.
        t1[0] = '{36'h1_0000_00A1, 1'b1, 1'b1, 1'b0, 36'h0,           2'b00};
        t1[1] = '{36'h1_0000_00A1, 1'b1, 1'b1, 1'b1, 36'h1_0000_00A1, 2'b01};
        t1[2] = '{36'h0_0000_00A2, 1'b1, 1'b1, 1'b1, 36'h0_0000_00A2, 2'b01};
        t1[3] = '{36'h2_0000_00A3, 1'b1, 1'b1, 1'b1, 36'h2_0000_00A3, 2'b01};
        t1[4] = '{36'h0,           1'b0, 1'b1, 1'b0, 36'h0,           2'b00};
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            in_valid  = {1'b0, t1[i].v0};
            in_data   = {36'h0, t1[i].d0};
            out_ready = t1[i].ordy;
            #1;
            check($sformatf("pkt3[%0d].out_valid", i), 36'(out_valid), 36'(t1[i].ev));
            if (t1[i].ev) check($sformatf("pkt3[%0d].out_data", i), out_data, t1[i].ed);
            check($sformatf("pkt3[%0d].in_ready", i), 36'(in_ready), 36'(t1[i].erdy));
            @(posedge sys_clk);
            #1;
        end

        // Channel 1 packet under downstream backpressure.
        q1 = '{36'h1_0000_00E1, 36'h0_0000_00E2, 36'h2_0000_00E3};
        cyc(1'b1, 1'b0, 36'h0,           2'b00, "bp0");
        cyc(1'b1, 1'b1, 36'h1_0000_00E1, 2'b10, "bp1");
        cyc(1'b0, 1'b1, 36'h0_0000_00E2, 2'b00, "bp2");
        cyc(1'b0, 1'b1, 36'h0_0000_00E2, 2'b00, "bp3");
        cyc(1'b1, 1'b1, 36'h0_0000_00E2, 2'b10, "bp4");
        cyc(1'b0, 1'b1, 36'h2_0000_00E3, 2'b00, "bp5");
        cyc(1'b1, 1'b1, 36'h2_0000_00E3, 2'b10, "bp6");
        set_stb = 1'b1; set_addr = 8'h05; set_data = 32'h0;
        cyc(1'b1, 1'b0, 36'h0,           2'b00, "bp7");
        set_stb = 1'b0;

        // Disable channel 1 mid-packet; current packet completes, next two are drained.
        q1 = '{36'h1_0000_00F1, 36'h0_0000_00F2, 36'h2_0000_00F3,
               36'h1_0000_00F4, 36'h2_0000_00F5, 36'h3_0000_00F6};
        cyc(1'b1, 1'b0, 36'h0,           2'b00, "dis0");
        set_stb = 1'b1; set_addr = 8'h00; set_data = 32'h1;
        cyc(1'b1, 1'b1, 36'h1_0000_00F1, 2'b10, "dis1");
        set_stb = 1'b0;
        cyc(1'b1, 1'b1, 36'h0_0000_00F2, 2'b10, "dis2");
        cyc(1'b1, 1'b1, 36'h2_0000_00F3, 2'b10, "dis3");
        cyc(1'b1, 1'b0, 36'h0,           2'b10, "dis4");
        cyc(1'b1, 1'b0, 36'h0,           2'b10, "dis5");
        check("dis.drop_one", 36'(drop_count), 36'd1);
        cyc(1'b1, 1'b0, 36'h0,           2'b10, "dis6");
        check("dis.drop_two", 36'(drop_count), 36'd2);
        cyc(1'b1, 1'b0, 36'h0,           2'b10, "dis7");
        check("dis.queue_drained", 36'(q1.size()), 36'd0);

        // Clear collides with an EOF drain: clear wins.
        q1 = '{36'h2_0000_00F9};
        set_stb = 1'b1; set_addr = 8'h01; set_data = 32'h0;
        cyc(1'b1, 1'b0, 36'h0,           2'b10, "clr0");
        set_stb = 1'b0;
        check("clr.drop_count", 36'(drop_count), 36'd0);
        check("clr.drained", 36'(q1.size()), 36'd0);

        // Reset in the middle of a channel 1 packet, both channels requesting afterwards.
        set_stb = 1'b1; set_addr = 8'h00; set_data = 32'h2;
        cyc(1'b1, 1'b0, 36'h0,           2'b10, "rst_mask");
        set_stb = 1'b0;
        q0 = '{36'h2_0000_0B01};
        q1 = '{36'h1_0000_0B11, 36'h0_0000_0B12, 36'h2_0000_0B13};
        cyc(1'b1, 1'b0, 36'h0,           2'b01, "rst0");
        check("rst.drop_pre", 36'(drop_count), 36'd1);
        cyc(1'b1, 1'b1, 36'h1_0000_0B11, 2'b11, "rst1");
        sys_rst = 1'b1;
        cyc(1'b1, 1'b1, 36'h0_0000_0B12, 2'b11, "rst2");
        sys_rst = 1'b0;
        check("rst.drop_count", 36'(drop_count), 36'd0);
        q0 = '{36'h1_0000_0B21, 36'h2_0000_0B22};
        cyc(1'b1, 1'b0, 36'h0,           2'b00, "rst3");
        cyc(1'b1, 1'b1, 36'h1_0000_0B21, 2'b01, "rst4");
        cyc(1'b1, 1'b1, 36'h2_0000_0B22, 2'b01, "rst5");
        cyc(1'b1, 1'b0, 36'h0,           2'b00, "rst6");
        cyc(1'b1, 1'b1, 36'h2_0000_0B13, 2'b10, "rst7");
        cyc(1'b1, 1'b0, 36'h0,           2'b00, "rst8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
